// File: rtl/imem_responder_pkg.sv
// Shared defaults and FSM state type for the instruction-memory refill responder.
package imem_responder_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 32;
  localparam int unsigned IMEM_BLOCK_BITS = 64;
  localparam int unsigned IMEM_LATENCY    = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_req_queue.sv
// Two-entry FIFO of pending block indices, with a lookup port used to coalesce
// duplicate requests against queued entries.
module imem_req_queue #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] query_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] data_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             vld0;
  logic             vld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) data_q[wr_ptr_q] <= push_data_i;
  end

  assign vld0    = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b0));
  assign vld1    = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b1));
  assign hit_o   = (vld0 && (data_q[0] == query_i)) || (vld1 && (data_q[1] == query_i));
  assign head_o  = data_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory model: queues I-cache refill requests,
// coalesces duplicates and returns one block per request after LATENCY cycles.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = IMEM_ADDR_WIDTH,
  parameter int unsigned BLOCK_BITS   = IMEM_BLOCK_BITS,
  parameter int unsigned LATENCY      = IMEM_LATENCY,
  parameter int unsigned MEM_IDX_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    req_ready,
  input  logic                    flush,
  input  logic                    init_we,
  input  logic [MEM_IDX_BITS-1:0] init_idx,
  input  logic [BLOCK_BITS-1:0]   init_data,
  output logic [BLOCK_BITS-1:0]   dram_response,
  output logic                    dram_response_valid,
  output logic                    busy
);

  localparam int unsigned DEPTH = 1 << MEM_IDX_BITS;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [BLOCK_BITS-1:0]   mem_q [DEPTH];
  imem_state_e             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MEM_IDX_BITS-1:0] cur_idx_q;

  logic [MEM_IDX_BITS-1:0] req_idx;
  logic [MEM_IDX_BITS-1:0] q_head;
  logic                    q_full;
  logic                    q_empty;
  logic                    q_hit;
  logic                    accept;
  logic                    coalesce;
  logic                    bypass;
  logic                    push;
  logic                    pop;
  logic [BLOCK_BITS-1:0]   rsp_word;
  logic                    unused_addr_bits;

  assign req_idx          = req_addr[MEM_IDX_BITS+2:3];
  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MEM_IDX_BITS+3], req_addr[2:0]};

  assign req_ready = !rst && !q_full && !flush;
  assign accept    = req_valid && req_ready;
  assign coalesce  = q_hit || ((state_q != ST_IDLE) && (req_idx == cur_idx_q));
  // An idle engine starts the new request immediately instead of queueing it.
  assign bypass    = accept && !coalesce && (state_q == ST_IDLE) && q_empty;
  assign push      = accept && !coalesce && !bypass;
  assign pop       = !flush && !q_empty && ((state_q == ST_IDLE) || (state_q == ST_RESP));

  imem_req_queue #(
    .WIDTH(MEM_IDX_BITS)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_i     (push),
    .push_data_i(req_idx),
    .pop_i      (pop),
    .query_i    (req_idx),
    .head_o     (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .hit_o      (q_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_idx_q <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q   <= ST_WAIT;
            cnt_q     <= CNT_LOAD;
            cur_idx_q <= q_head;
          end else if (bypass) begin
            state_q   <= ST_WAIT;
            cnt_q     <= CNT_LOAD;
            cur_idx_q <= req_idx;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_RESP: begin
          if (pop) begin
            state_q   <= ST_WAIT;
            cnt_q     <= CNT_LOAD;
            cur_idx_q <= q_head;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Backing store is preload-only and deliberately survives reset.
  always_ff @(posedge clk) begin
    if (init_we) mem_q[init_idx] <= init_data;
  end

  // Write-first: a same-cycle preload to the responding index is forwarded.
  always_comb begin
    rsp_word = mem_q[cur_idx_q];
    if (init_we && (init_idx == cur_idx_q)) rsp_word = init_data;
  end

  assign dram_response_valid = (state_q == ST_RESP) && !flush && !rst;
  assign dram_response       = dram_response_valid ? rsp_word : '0;
  assign busy                = !rst && ((state_q != ST_IDLE) || !q_empty);

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: LATENCY=10 and LATENCY=1 instances.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam int unsigned AW = 32;
  localparam int unsigned BB = 64;
  localparam int unsigned IW = 10;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          init_we;
  logic [IW-1:0] init_idx;
  logic [BB-1:0] init_data;

  logic          req_valid0, req_ready0, valid0, busy0;
  logic [AW-1:0] req_addr0;
  logic [BB-1:0] rsp0;
  logic          req_valid1, req_ready1, valid1, busy1;
  logic [AW-1:0] req_addr1;
  logic [BB-1:0] rsp1;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    logic [BB-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [BB-1:0] model [1024];

  imem_responder #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB), .LATENCY(10), .MEM_IDX_BITS(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
    .flush(flush), .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
    .dram_response(rsp0), .dram_response_valid(valid0), .busy(busy0)
  );

  imem_responder #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB), .LATENCY(1), .MEM_IDX_BITS(IW)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .flush(flush), .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
    .dram_response(rsp1), .dram_response_valid(valid1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitors: pop the scoreboard on every strobe, otherwise require zero data.
  always @(negedge clk) begin
    exp_t e;
    if (valid0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe0: got data %h at cycle %0d, required no strobe", rsp0, cyc);
      end else begin
        e = q0.pop_front();
        chk("rsp0_data", rsp0, e.data);
        chk("rsp0_cycle", BB'(cyc), BB'(e.cyc));
      end
    end else begin
      chk("rsp0_zero_when_idle", rsp0, '0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe1: got data %h at cycle %0d, required no strobe", rsp1, cyc);
      end else begin
        e = q1.pop_front();
        chk("rsp1_data", rsp1, e.data);
        chk("rsp1_cycle", BB'(cyc), BB'(e.cyc));
      end
    end else begin
      chk("rsp1_zero_when_idle", rsp1, '0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [BB-1:0] data);
    init_we   = 1'b1;
    init_idx  = IW'(idx);
    init_data = data;
    tick(1);
    init_we    = 1'b0;
    model[idx] = data;
  endtask

  // Called just after a rising edge; returns the accepting edge number.
  task automatic issue(input bit sel, input logic [AW-1:0] addr, output int k);
    bit r;
    int n;
    n = 0;
    k = -1;
    if (sel) begin req_valid1 = 1'b1; req_addr1 = addr; end
    else     begin req_valid0 = 1'b1; req_addr0 = addr; end
    while (k < 0 && n < 50) begin
      @(negedge clk);
      r = sel ? req_ready1 : req_ready0;
      tick(1);
      n++;
      if (r) k = cyc;
    end
    if (sel) req_valid1 = 1'b0;
    else     req_valid0 = 1'b0;
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL accept_timeout: got no acceptance of %h after %0d cycles, required acceptance", addr, n);
      k = cyc;
    end
  endtask

  task automatic push_exp(input bit sel, input logic [BB-1:0] data, input int c);
    exp_t e;
    e.data = data;
    e.cyc  = c;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d responses outstanding, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    tick(1);
    chk("busy0_after_drain", BB'(busy0), '0);
    chk("busy1_after_drain", BB'(busy1), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, k1, k2, k3;
    rst = 1'b1; flush = 1'b0; init_we = 1'b0; init_idx = '0; init_data = '0;
    req_valid0 = 1'b0; req_addr0 = '0; req_valid1 = 1'b0; req_addr1 = '0;
    cyc = 0; checks = 0; errors = 0;

    // Preload while reset is held: the store must keep these across reset.
    preload(5,    64'hDEADBEEF_CAFEF00D);
    preload(1,    64'h1111_0000_0000_0001);
    preload(2,    64'h2222_0000_0000_0002);
    preload(3,    64'h3333_0000_0000_0003);
    preload(4,    64'h4444_0000_0000_0004);
    preload(6,    64'h6666_0000_0000_0006);
    preload(7,    64'h7777_0000_0000_0007);
    preload(8,    64'h8888_0000_0000_0008);
    preload(9,    64'h9999_0000_0000_0009);
    preload(1023, 64'hFFFF_0000_0000_03FF);

    req_valid0 = 1'b1; req_valid1 = 1'b1; req_addr0 = 32'h28; req_addr1 = 32'h28;
    #1;
    chk("rst_ready0", BB'(req_ready0), '0);
    chk("rst_valid0", BB'(valid0), '0);
    chk("rst_busy0",  BB'(busy0), '0);
    chk("rst_ready1", BB'(req_ready1), '0);
    chk("rst_busy1",  BB'(busy1), '0);
    tick(1);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    rst = 1'b0;
    tick(2);
    chk("post_rst_ready0", BB'(req_ready0), 64'd1);
    chk("post_rst_busy0",  BB'(busy0), '0);

    // Basic refill of idx 5 with full latency.
    issue(0, 32'h0000_0028, k);
    push_exp(0, 64'hDEADBEEF_CAFEF00D, k + 10);
    chk("busy0_in_flight", BB'(busy0), 64'd1);
    drain();

    // Three distinct back-to-back requests: in order, LATENCY+1 apart.
    issue(0, 32'h08, k1);
    issue(0, 32'h10, k2);
    issue(0, 32'h18, k3);
    chk("ready0_low_when_full", BB'(req_ready0), '0);
    push_exp(0, model[1], k1 + 10);
    push_exp(0, model[2], k1 + 21);
    push_exp(0, model[3], k1 + 32);
    tick(9);
    chk("ready0_after_first_pop", BB'(req_ready0), 64'd1);
    drain();

    // Same address held for 12 edges coalesces into one response.
    issue(0, 32'h20, k);
    push_exp(0, model[4], k + 10);
    req_valid0 = 1'b1; req_addr0 = 32'h20;
    tick(11);
    req_valid0 = 1'b0;
    drain();

    // Flush mid-WAIT with one queued: nothing returns, new request is clean.
    issue(0, 32'h30, k);
    issue(0, 32'h38, k2);
    tick(3);
    flush = 1'b1; req_valid0 = 1'b1; req_addr0 = 32'h40;
    #1;
    chk("ready0_low_during_flush", BB'(req_ready0), '0);
    tick(1);
    flush = 1'b0; req_valid0 = 1'b0;
    chk("busy0_after_flush", BB'(busy0), '0);
    tick(30);
    issue(0, 32'h28, k);
    push_exp(0, model[5], k + 10);
    drain();

    // Preload write during RESP to the responding index is forwarded, then stored.
    issue(0, 32'h48, k);
    push_exp(0, 64'hABCD_1234_5678_9ABC, k + 10);
    tick(10);
    init_we = 1'b1; init_idx = IW'(9); init_data = 64'hABCD_1234_5678_9ABC;
    tick(1);
    init_we = 1'b0;
    model[9] = 64'hABCD_1234_5678_9ABC;
    drain();
    issue(0, 32'h48, k);
    push_exp(0, model[9], k + 10);
    drain();

    // Reset during RESP drops the strobe at once and nothing follows.
    issue(0, 32'h28, k);
    push_exp(0, model[5], k + 10);
    tick(10);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_in_resp_valid0", BB'(valid0), '0);
    chk("rst_in_resp_data0",  rsp0, '0);
    chk("rst_in_resp_busy0",  BB'(busy0), '0);
    tick(3);
    rst = 1'b0;
    tick(25);
    drain();

    // LATENCY=1: top address wraps to idx 1023, answered after one edge.
    issue(1, 32'hFFFF_FFF8, k);
    push_exp(1, model[1023], k + 1);
    drain();
    issue(1, 32'h0000_0028, k);
    push_exp(1, model[5], k + 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
